reply_bus_arbiter: RTL and testbench

- Round-robin scheduler for the shared 8-bit local-link reply FIFO bus. Reply sources (ARP reply, IP/ICMP reply, UDP reply mux) are selected by a 6-bit fifo read address.
- Sits between the addressed source FIFOs and the Ethernet TX framer.
- Picks one source with a complete frame pending, drives its address, forwards exactly one frame (sof..eof) downstream, then rotates to the next source.
- A watchdog flushes frames that stall.

---
 rtl/reply_bus_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_reply_bus_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reply_bus_arbiter.sv
// Round-robin arbiter for the shared 8-bit local-link reply FIFO bus.
// It grants one source per frame, forwards the frame and flushes frames that stall or lack a start-of-frame.
module reply_bus_arbiter #(
  parameter int         MaxCh         = 3,
  parameter logic [5:0] BaseAddr      = 6'd0,
  parameter int         SettleCycles  = 2,
  parameter int         TimeoutCycles = 4096
) (
  input  logic             rd_clk,
  input  logic             reset,
  input  logic [MaxCh-1:0] src_frame_avail,
  output logic [5:0]       bus_fifo_addr,
  input  logic             bus_sof_n,
  input  logic [7:0]       bus_data,
  input  logic             bus_eof_n,
  input  logic             bus_src_rdy_n,
  output logic             bus_dst_rdy_n,
  output logic             out_sof_n,
  output logic [7:0]       out_data,
  output logic             out_eof_n,
  output logic             out_src_rdy_n,
  input  logic             out_dst_rdy_n,
  output logic [5:0]       cur_ch,
  output logic             busy,
  output logic [15:0]      frame_cnt,
  output logic [7:0]       timeout_cnt
);

  typedef enum logic [1:0] {IDLE, SETTLE, XFER, FLUSH} state_e;

  localparam logic [15:0] SettleLast = 16'((SettleCycles > 1) ? SettleCycles - 1 : 0);
  localparam logic [15:0] WdLast     = 16'((TimeoutCycles > 1) ? TimeoutCycles - 1 : 0);
  localparam logic [5:0]  LastInit   = 6'(MaxCh - 1);

  state_e      state_q, state_d;
  logic [5:0]  cur_q, cur_d;
  logic [5:0]  last_q, last_d;
  logic [5:0]  addr_q, addr_d;
  logic [15:0] settle_q, settle_d;
  logic [15:0] wd_q, wd_d;
  logic        first_q, first_d;
  logic [15:0] frame_q, frame_d;
  logic [7:0]  tmo_q, tmo_d;

  logic        pick_found_s;
  logic [5:0]  pick_ch_s;
  logic        beat_s;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Rotating priority search starting just after the last granted channel.
  always_comb begin
    pick_found_s = 1'b0;
    pick_ch_s    = 6'd0;
    for (int k = 1; k <= MaxCh; k++) begin
      if (!pick_found_s && src_frame_avail[(int'(last_q) + k) % MaxCh]) begin
        pick_found_s = 1'b1;
        pick_ch_s    = 6'((int'(last_q) + k) % MaxCh);
      end
    end
  end

  // Bus handshake, downstream outputs and next-state decode.
  always_comb begin
    state_d       = state_q;
    cur_d         = cur_q;
    last_d        = last_q;
    addr_d        = addr_q;
    settle_d      = settle_q;
    wd_d          = wd_q;
    first_d       = first_q;
    frame_d       = frame_q;
    tmo_d         = tmo_q;
    bus_dst_rdy_n = 1'b1;
    out_sof_n     = 1'b1;
    out_data      = 8'd0;
    out_eof_n     = 1'b1;
    out_src_rdy_n = 1'b1;

    case (state_q)
      XFER: begin
        // A first beat without sof is swallowed here so it never reaches the consumer.
        if (first_q && bus_sof_n) begin
          bus_dst_rdy_n = 1'b0;
        end else begin
          bus_dst_rdy_n = out_dst_rdy_n;
          out_sof_n     = bus_sof_n;
          out_data      = bus_data;
          out_eof_n     = bus_eof_n;
          out_src_rdy_n = bus_src_rdy_n;
        end
      end
      FLUSH:   bus_dst_rdy_n = 1'b0;
      default: bus_dst_rdy_n = 1'b1;
    endcase

    beat_s = !bus_src_rdy_n && !bus_dst_rdy_n;

    case (state_q)
      IDLE: begin
        if (pick_found_s) begin
          cur_d    = pick_ch_s;
          addr_d   = BaseAddr + pick_ch_s;
          settle_d = 16'd0;
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_q >= SettleLast) begin
          wd_d    = 16'd0;
          first_d = 1'b1;
          state_d = XFER;
        end else begin
          settle_d = settle_q + 16'd1;
        end
      end
      XFER: begin
        if (beat_s) begin
          wd_d    = 16'd0;
          first_d = 1'b0;
          if (!bus_eof_n) begin
            if (!(first_q && bus_sof_n)) begin
              frame_d = frame_q + 16'd1;
            end
            last_d  = cur_q;
            state_d = IDLE;
          end else if (first_q && bus_sof_n) begin
            state_d = FLUSH;
          end
        end else if (wd_q == WdLast) begin
          wd_d    = 16'd0;
          tmo_d   = sat_inc8(tmo_q);
          state_d = FLUSH;
        end else begin
          wd_d = wd_q + 16'd1;
        end
      end
      FLUSH: begin
        if (beat_s) begin
          wd_d = 16'd0;
          if (!bus_eof_n) begin
            last_d  = cur_q;
            state_d = IDLE;
          end
        end else if (wd_q == WdLast) begin
          // Source stopped mid-flush: give up on the eof and release the bus.
          wd_d    = 16'd0;
          tmo_d   = sat_inc8(tmo_q);
          last_d  = cur_q;
          state_d = IDLE;
        end else begin
          wd_d = wd_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge rd_clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cur_q    <= 6'd0;
      last_q   <= LastInit;
      addr_q   <= BaseAddr;
      settle_q <= 16'd0;
      wd_q     <= 16'd0;
      first_q  <= 1'b0;
      frame_q  <= 16'd0;
      tmo_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      last_q   <= last_d;
      addr_q   <= addr_d;
      settle_q <= settle_d;
      wd_q     <= wd_d;
      first_q  <= first_d;
      frame_q  <= frame_d;
      tmo_q    <= tmo_d;
    end
  end

  assign bus_fifo_addr = addr_q;
  assign cur_ch        = cur_q;
  assign busy          = (state_q != IDLE);
  assign frame_cnt     = frame_q;
  assign timeout_cnt   = tmo_q;

endmodule

// File: tb/tb_reply_bus_arbiter.sv
// Directed bench for reply_bus_arbiter: a three-source FIFO model feeds the bus,
// and the forwarded beats are collected and compared with hand-computed values.
module tb_reply_bus_arbiter;

  localparam int NCH = 3;

  logic           rd_clk = 1'b0;
  logic           reset;
  logic [NCH-1:0] src_frame_avail;
  logic [5:0]     bus_fifo_addr;
  logic           bus_sof_n, bus_eof_n, bus_src_rdy_n, bus_dst_rdy_n;
  logic [7:0]     bus_data;
  logic           out_sof_n, out_eof_n, out_src_rdy_n, out_dst_rdy_n;
  logic [7:0]     out_data;
  logic [5:0]     cur_ch;
  logic           busy;
  logic [15:0]    frame_cnt;
  logic [7:0]     timeout_cnt;

  reply_bus_arbiter #(
    .MaxCh(NCH), .BaseAddr(6'd0), .SettleCycles(2), .TimeoutCycles(16)
  ) dut (
    .rd_clk(rd_clk), .reset(reset), .src_frame_avail(src_frame_avail),
    .bus_fifo_addr(bus_fifo_addr), .bus_sof_n(bus_sof_n), .bus_data(bus_data),
    .bus_eof_n(bus_eof_n), .bus_src_rdy_n(bus_src_rdy_n), .bus_dst_rdy_n(bus_dst_rdy_n),
    .out_sof_n(out_sof_n), .out_data(out_data), .out_eof_n(out_eof_n),
    .out_src_rdy_n(out_src_rdy_n), .out_dst_rdy_n(out_dst_rdy_n), .cur_ch(cur_ch),
    .busy(busy), .frame_cnt(frame_cnt), .timeout_cnt(timeout_cnt)
  );

  always #5 rd_clk = ~rd_clk;

  int         frames[NCH], flen[NCH], ptr[NCH], stall_at[NCH], stall_rem[NCH];
  logic [7:0] base[NCH];
  bit         nosof[NCH];
  bit         beat_pending;
  int         beat_ch;
  bit         cons_hold;
  logic [7:0] q_data[$];
  logic [1:0] q_flg[$];
  int         grants[$];
  int         n_vec = 0;
  int         n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Source model: the addressed FIFO presents its current beat unless empty or stalled.
  task automatic drive();
    int ch;
    for (int i = 0; i < NCH; i++) src_frame_avail[i] = (frames[i] > 0);
    out_dst_rdy_n = cons_hold;
    ch = int'(bus_fifo_addr);
    if (ch < NCH && frames[ch] > 0 && !(ptr[ch] == stall_at[ch] && stall_rem[ch] > 0)) begin
      bus_src_rdy_n = 1'b0;
      bus_data      = base[ch] + 8'(ptr[ch]);
      bus_sof_n     = !(ptr[ch] == 0 && !nosof[ch]);
      bus_eof_n     = !(ptr[ch] == flen[ch] - 1);
    end else begin
      bus_src_rdy_n = 1'b1;
      bus_data      = 8'd0;
      bus_sof_n     = 1'b1;
      bus_eof_n     = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge rd_clk);
    #1;
    if (beat_pending) begin
      ptr[beat_ch]++;
      if (ptr[beat_ch] == flen[beat_ch]) begin
        ptr[beat_ch] = 0;
        frames[beat_ch]--;
      end
    end
    for (int i = 0; i < NCH; i++)
      if (ptr[i] == stall_at[i] && stall_rem[i] > 0) stall_rem[i]--;
    drive();
    @(negedge rd_clk);
    beat_pending = !bus_src_rdy_n && !bus_dst_rdy_n;
    beat_ch      = int'(bus_fifo_addr);
    if (!out_src_rdy_n && !out_dst_rdy_n) begin
      q_data.push_back(out_data);
      q_flg.push_back({out_sof_n, out_eof_n});
      if (!out_sof_n) grants.push_back(int'(cur_ch));
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < NCH; i++) begin
      frames[i] = 0; flen[i] = 1; ptr[i] = 0; base[i] = 8'd0;
      stall_at[i] = -1; stall_rem[i] = 0; nosof[i] = 1'b0;
    end
    q_data.delete(); q_flg.delete(); grants.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cons_hold = 1'b0;
    clear_model();
    drive();
    @(negedge rd_clk);
    @(negedge rd_clk);
    reset = 1'b0;
    beat_pending = 1'b0;
  endtask

  task automatic add_frame(input int ch, input int n, input logic [7:0] b);
    frames[ch] = frames[ch] + 1; flen[ch] = n; base[ch] = b;
  endtask

  task automatic wait_frames(input string tag, input int target, input int budget);
    int n = 0;
    while (frame_cnt != 16'(target) && n < budget) begin tick(); n++; end
    check_eq(tag, 32'(frame_cnt), 32'(target));
  endtask

  initial begin
    reset = 1'b1;
    beat_pending = 1'b0;
    beat_ch = 0;
    cons_hold = 1'b0;
    clear_model();
    drive();

    // Reset state
    do_reset();
    check_eq("rst_addr", 32'(bus_fifo_addr), 32'd0);
    check_eq("rst_dst", 32'(bus_dst_rdy_n), 32'd1);
    check_eq("rst_out", 32'({out_sof_n, out_eof_n, out_src_rdy_n}), 32'h7);
    check_eq("rst_data", 32'(out_data), 32'd0);
    check_eq("rst_cnts", 32'({cur_ch, busy, frame_cnt, timeout_cnt}), 32'd0);

    // 5-byte frame on ch1
    add_frame(1, 5, 8'hA0);
    drive();
    tick();
    check_eq("t1_addr", 32'(bus_fifo_addr), 32'd1);
    check_eq("t1_busy", 32'(busy), 32'd1);
    tick();
    check_eq("t1_settle", 32'({bus_dst_rdy_n, out_src_rdy_n}), 32'h3);
    tick();
    check_eq("t1_first", 32'({out_src_rdy_n, out_sof_n, out_data}), 32'h0A0);
    for (int n = 0; n < 20 && busy; n++) tick();
    check_eq("t1_idle", 32'(busy), 32'd0);
    check_eq("t1_fcnt", 32'(frame_cnt), 32'd1);
    check_eq("t1_len", 32'(q_data.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      check_eq("t1_data", 32'(q_data[i]), 32'(8'hA0 + 8'(i)));
      check_eq("t1_flg", 32'(q_flg[i]), 32'({i != 0, i != 4}));
    end

    // All sources request, 4-byte frames, rotation 0,1,2,0,1,2
    do_reset();
    for (int c = 0; c < NCH; c++) begin
      add_frame(c, 4, 8'h10 * 8'(c + 1));
      add_frame(c, 4, 8'h10 * 8'(c + 1));
    end
    drive();
    wait_frames("t2_fcnt", 6, 200);
    check_eq("t2_len", 32'(q_data.size()), 32'd24);
    check_eq("t2_ngrant", 32'(grants.size()), 32'd6);
    for (int i = 0; i < 6; i++) check_eq("t2_grant", 32'(grants[i]), 32'(i % 3));
    for (int i = 0; i < 24; i++) begin
      check_eq("t2_data", 32'(q_data[i]), 32'(8'h10 * 8'((i / 4) % 3 + 1) + 8'(i % 4)));
      check_eq("t2_flg", 32'(q_flg[i]), 32'({i % 4 != 0, i % 4 != 3}));
    end

    // Consumer back-pressure for 3 cycles mid-frame
    do_reset();
    add_frame(0, 6, 8'h50);
    drive();
    repeat (4) tick();
    cons_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("t3_hold", 32'({bus_dst_rdy_n, out_data}), 32'h152);
    end
    cons_hold = 1'b0;
    wait_frames("t3_fcnt", 1, 50);
    check_eq("t3_len", 32'(q_data.size()), 32'd6);
    for (int i = 0; i < 6; i++) check_eq("t3_data", 32'(q_data[i]), 32'(8'h50 + 8'(i)));

    // ch2 stalls after 2 beats: watchdog flush, then ch0 is granted
    do_reset();
    add_frame(2, 6, 8'h70);
    stall_at[2] = 2;
    stall_rem[2] = 20;
    drive();
    tick();
    add_frame(0, 4, 8'h10);
    add_frame(1, 4, 8'h20);
    repeat (19) tick();
    check_eq("t4_pre_tmo", 32'({busy, timeout_cnt}), 32'h100);
    tick();
    check_eq("t4_tmo", 32'(timeout_cnt), 32'd1);
    check_eq("t4_fcnt0", 32'(frame_cnt), 32'd0);
    wait_frames("t4_fcnt", 2, 200);
    check_eq("t4_tmo_end", 32'(timeout_cnt), 32'd1);
    check_eq("t4_len", 32'(q_data.size()), 32'd10);
    check_eq("t4_d0", 32'({q_flg[0], q_data[0]}), 32'h170);
    check_eq("t4_d1", 32'({q_flg[1], q_data[1]}), 32'h371);
    check_eq("t4_ngrant", 32'(grants.size()), 32'd3);
    check_eq("t4_g0", 32'(grants[0]), 32'd2);
    check_eq("t4_g1", 32'(grants[1]), 32'd0);
    check_eq("t4_g2", 32'(grants[2]), 32'd1);
    check_eq("t4_drained", 32'(frames[2]), 32'd0);

    // First beat without sof: swallowed and drained
    do_reset();
    add_frame(1, 4, 8'h90);
    nosof[1] = 1'b1;
    drive();
    repeat (3) tick();
    check_eq("t5_swallow", 32'({out_src_rdy_n, bus_dst_rdy_n}), 32'h2);
    for (int n = 0; n < 50 && (busy || frames[1] != 0); n++) tick();
    check_eq("t5_drained", 32'(frames[1]), 32'd0);
    check_eq("t5_idle", 32'(busy), 32'd0);
    check_eq("t5_len", 32'(q_data.size()), 32'd0);
    check_eq("t5_cnts", 32'({frame_cnt, timeout_cnt}), 32'd0);

    // Reset on beat 3 of a 10-byte frame
    nosof[1] = 1'b0;
    add_frame(1, 10, 8'hB0);
    drive();
    tick();
    add_frame(0, 2, 8'hC0);
    repeat (4) tick();
    check_eq("t6_beat3", 32'({out_src_rdy_n, out_data}), 32'h0B2);
    #1 reset = 1'b1;
    #1;
    check_eq("t6_rst_out", 32'({out_sof_n, out_eof_n, out_src_rdy_n, bus_dst_rdy_n}), 32'hF);
    check_eq("t6_rst_regs", 32'({bus_fifo_addr, cur_ch, busy, out_data}), 32'd0);
    @(posedge rd_clk);
    #2 reset = 1'b0;
    beat_pending = 1'b0;
    ptr[1] = 0;
    q_data.delete(); q_flg.delete(); grants.delete();
    drive();
    @(negedge rd_clk);
    wait_frames("t6_fcnt", 1, 100);
    check_eq("t6_ngrant", 32'(grants.size()), 32'd1);
    check_eq("t6_g0", 32'(grants[0]), 32'd0);
    check_eq("t6_d0", 32'(q_data[0]), 32'hC0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
